// File: rtl/rns_reverse_converter.sv
// rns_reverse_converter
//   Residue-to-binary converter for the moduli set {2^N-1, 2^N, 2^N+1}.
//   Three register stages, one triple per cycle, valid/ready on both sides
//   with a single global stall (out_valid & ~out_ready) that freezes every
//   stage.
//
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input triple present
//   in_ready   converter accepts a triple this cycle (= ~stall)
//   r1         residue mod 2^N-1 (value 2^N-1 is an alias of 0)
//   r2         residue mod 2^N
//   r3         residue mod 2^N+1 (values above 2^N are flagged)
//   out_valid  x / out_err hold a result
//   out_ready  downstream takes the result
//   x          binary value in [0, 2^3N-2^N)
//   out_err    r3 was out of range; x is forced to 0
//
//   An accepted triple lands in stage 1 on its accept edge and shows up on
//   out_valid after the third rising edge, counting the accept edge as the
//   first.
module rns_reverse_converter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   r1,
    input  logic [N-1:0]   r2,
    input  logic [N:0]     r3,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3*N-1:0] x,
    output logic           out_err
);
    localparam int           STAGES  = 3;
    localparam logic [N-1:0] M1      = {N{1'b1}};
    localparam logic [N:0]   M3      = {1'b1, {(N-1){1'b0}}, 1'b1};
    // (m3+1)/2 = 2^(N-1)+1, used to halve an odd value modulo m3
    localparam logic [N:0]   HALF_M3 = {2'b01, {(N-2){1'b0}}, 1'b1};
    localparam logic [N:0]   R3_MAX  = {1'b1, {N{1'b0}}};

    typedef struct packed {
        logic [N-1:0] a;
        logic [N:0]   d;
        logic [N-1:0] r2;
        logic         err;
    } s1_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N:0]   k;
        logic [N-1:0] r2;
        logic         err;
    } s2_t;

    logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;
    s1_t               s1_q, s1_d;
    s2_t               s2_q, s2_d;
    logic [3*N-1:0]    x_q, x_d;
    logic              err_q, err_d;
    logic              stall, advance;

    assign out_valid = vld_pipe_q[STAGES-1];
    assign stall     = out_valid & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = advance;
    assign x         = x_q;
    assign out_err   = err_q;

    // ---------------- stage 1: a = (r1-r2) mod m1, d = (r2-r3) mod m3
    logic [N:0]   a_sum;
    logic [N-1:0] a_fold, a_s1;
    logic [N:0]   d_s1;
    logic         err_s1;

    always_comb begin
        // r1 - r2 mod (2^N-1) = r1 + ~r2 with end-around carry
        a_sum  = {1'b0, r1} + {1'b0, ~r2};
        a_fold = a_sum[N-1:0] + {{(N-1){1'b0}}, a_sum[N]};
        // all-ones is the second encoding of zero (also covers r1 = 2^N-1)
        a_s1   = (a_fold == M1) ? '0 : a_fold;
        // borrow adds m3 back; the N+1 bit wrap is harmless since d < m3
        if ({1'b0, r2} >= r3) d_s1 = {1'b0, r2} - r3;
        else                  d_s1 = {1'b0, r2} + M3 - r3;
        err_s1 = (r3 > R3_MAX);
    end

    // ---------------- stage 2: k = (d-a) * 2^(N-1) mod m3
    // 2^(N-1) == -(1/2) mod m3, so k is the negated modular half of (d-a).
    logic [N:0] e_s2, half_s2, k_s2;

    always_comb begin
        if (s1_q.d >= {1'b0, s1_q.a}) e_s2 = s1_q.d - {1'b0, s1_q.a};
        else                          e_s2 = s1_q.d + M3 - {1'b0, s1_q.a};
        // odd e: (e+m3)/2 = floor(e/2) + (m3+1)/2
        half_s2 = {1'b0, e_s2[N:1]} + (e_s2[0] ? HALF_M3 : '0);
        k_s2    = (half_s2 == '0) ? '0 : M3 - half_s2;
    end

    // ---------------- stage 3: Y = a + m1*k = a + (k<<N) - k, x = {Y, r2}
    // Computed mod 2^2N; the true Y is below 2^2N-1 so truncation is exact.
    logic [2*N-1:0] y_s3;

    always_comb begin
        y_s3 = {s2_q.k[N-1:0], {N{1'b0}}} - {{(N-1){1'b0}}, s2_q.k}
             + {{N{1'b0}}, s2_q.a};
    end

    // ---------------- pipeline advance
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        x_d        = x_q;
        err_d      = err_q;
        if (advance) begin
            vld_pipe_d = {vld_pipe_q[STAGES-2:0], in_valid};
            s1_d.a     = a_s1;
            s1_d.d     = d_s1;
            s1_d.r2    = r2;
            s1_d.err   = err_s1;
            s2_d.a     = s1_q.a;
            s2_d.k     = k_s2;
            s2_d.r2    = s1_q.r2;
            s2_d.err   = s1_q.err;
            // output regs only load real data so x holds across bubbles
            if (vld_pipe_q[STAGES-2]) begin
                x_d   = s2_q.err ? '0 : {y_s3, s2_q.r2};
                err_d = s2_q.err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            x_q        <= '0;
            err_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            x_q        <= x_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_rns_reverse_converter.sv
// Bench for rns_reverse_converter at N=4 (m1=15, m2=16, m3=17, M=4080).
// Expected results come from a brute-force CRT search over x = r2 + 16*j.
module tb_rns_reverse_converter;
    localparam int N = 4;
    localparam int M = 4080;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   r1;
    logic [N-1:0]   r2;
    logic [N:0]     r3;
    logic           out_valid;
    logic           out_ready;
    logic [3*N-1:0] x;
    logic           out_err;

    int checks = 0;
    int errors = 0;

    rns_reverse_converter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // returns {err, x}
    function automatic logic [12:0] ref_conv(input int a1, input int a2, input int a3);
        if (a3 > 16) return {1'b1, 12'd0};
        for (int j = 0; j < 255; j++) begin
            int v;
            v = a2 + 16 * j;
            if ((v % 15) == (a1 % 15) && (v % 17) == a3) return {1'b0, 12'(v)};
        end
        return '1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one isolated conversion, out_ready held high; verifies 3-edge latency
    task automatic single(input string tag, input int a1, input int a2, input int a3,
                          input int exp_x, input logic exp_err);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        r1 = 4'(a1); r2 = 4'(a2); r3 = 5'(a3);
        @(posedge clk); #1;                       // accept edge
        in_valid = 1'b0;
        r1 = 4'($urandom); r2 = 4'($urandom); r3 = 5'($urandom);
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_x"}, x, exp_x);
        chk({tag, "_err"}, out_err, exp_err);
        @(posedge clk); #1;
        chk({tag, "_one_cycle"}, out_valid, 0);
    endtask

    logic [12:0] expq[$];
    logic [12:0] e;
    logic        prev_stall;
    logic [11:0] prev_x;
    logic        prev_err;
    int          sent, got, cyc;
    int          ra, rb, rc;

    initial begin
        // ---- reset with random inputs
        rst       = 1'b1;
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        r1 = 4'($urandom); r2 = 4'($urandom); r3 = 5'($urandom);
        #1;
        chk("rst_async_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_x", x, 0);
        chk("rst_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // ---- idle: no result without inputs
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom);
            r1 = 4'($urandom); r2 = 4'($urandom); r3 = 5'($urandom);
            #1;
            chk("idle_valid", out_valid, 0);
        end

        // ---- directed conversions
        single("basic",     10, 8, 14, 1000, 1'b0);
        single("zero",       0, 0,  0,    0, 1'b0);
        single("max",       14, 15, 16, 4079, 1'b0);
        single("r1_alias",  15, 0,  0,    0, 1'b0);
        single("r3_illegal", 0, 0, 20,    0, 1'b1);

        // ---- streaming all values with random backpressure
        sent = 0; got = 0; cyc = 0;
        prev_stall = 1'b0; prev_x = '0; prev_err = 1'b0;
        while ((sent < M || got < M) && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < M) begin
                in_valid = ($urandom_range(0, 7) != 0);
                ra = ((sent % 15) == 0 && $urandom_range(0, 1) == 1) ? 15 : sent % 15;
                rb = sent % 16;
                rc = sent % 17;
                r1 = 4'(ra); r2 = 4'(rb); r3 = 5'(rc);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_x", {out_err, x}, {prev_err, prev_x});
            end
            if (out_valid && out_ready) begin
                chk("stream_no_extra", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("stream_result", {out_err, x}, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref_conv(ra, rb, rc));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_x     = x;
            prev_err   = out_err;
        end
        chk("stream_budget", cyc < 30000, 1);
        chk("stream_sent", sent, M);
        chk("stream_got", got, M);
        chk("stream_drained", expq.size(), 0);

        // ---- reset with three triples in flight
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            r1 = 4'($urandom); r2 = 4'($urandom); r3 = 5'($urandom_range(0, 16));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid_drop", out_valid, 0);
        chk("midrst_err", out_err, 0);
        chk("midrst_x", x, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", out_valid, 0);
        end
        ra = $urandom_range(0, 15); rb = $urandom_range(0, 15); rc = $urandom_range(0, 16);
        e  = ref_conv(ra, rb, rc);
        single("post_rst", ra, rb, rc, e[11:0], e[12]);

        // ---- a few random single conversions, including illegal r3
        for (int i = 0; i < 4; i++) begin
            ra = $urandom_range(0, 15); rb = $urandom_range(0, 15); rc = $urandom_range(0, 31);
            e  = ref_conv(ra, rb, rc);
            single("random", ra, rb, rc, e[11:0], e[12]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
